counter_0_31_auto_sel: RTL and testbench

- Downstream consumer of the 4-to-1 tick multiplexer in the 0–31 auto-frequency counter design.
- Counts selected tick pulses from 0 to 31 and wraps.
- After a programmable number of full laps, advances the 2-bit frequency select fed back to the mux: 0.5 Hz -> 1 Hz -> 2 Hz -> 10 Hz -> 0.5 Hz.
- Also provides BCD digits for the 7-segment display stage.

---
 rtl/counter_0_31_auto_sel_pkg.sv | 34 +++
 rtl/counter_0_31_auto_sel_bin2bcd_5b.sv | 27 ++
 rtl/counter_0_31_auto_sel.sv | 88 ++++++++
 tb/tb_counter_0_31_auto_sel.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/counter_0_31_auto_sel_pkg.sv
// Shared constants and select-state encoding for the 0..31 auto-frequency counter design.
// Used by the counter, the tick mux and the display stage.
package counter_0_31_auto_sel_pkg;

    localparam logic [1:0] SEL_05HZ = 2'b00;
    localparam logic [1:0] SEL_1HZ  = 2'b01;
    localparam logic [1:0] SEL_2HZ  = 2'b10;
    localparam logic [1:0] SEL_10HZ = 2'b11;

    localparam int unsigned DEF_CNT_MAX = 31;
    localparam int unsigned DEF_CNT_W   = 5;
    localparam int unsigned LAP_W       = 4;

    typedef enum logic [1:0] {
        StSel05 = SEL_05HZ,
        StSel1  = SEL_1HZ,
        StSel2  = SEL_2HZ,
        StSel10 = SEL_10HZ
    } sel_state_e;

    // Frequency rotation: 0.5 Hz -> 1 Hz -> 2 Hz -> 10 Hz -> 0.5 Hz.
    function automatic sel_state_e sel_next(input sel_state_e cur);
        sel_state_e nxt;
        unique case (cur)
            StSel05: nxt = StSel1;
            StSel1:  nxt = StSel2;
            StSel2:  nxt = StSel10;
            StSel10: nxt = StSel05;
            default: nxt = StSel05;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/counter_0_31_auto_sel_bin2bcd_5b.sv
// Combinational 5-bit binary (0..31) to two-digit BCD converter.
// Also instantiated by the display stage.
module bin2bcd_5b (
    input  logic [4:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units
);

    always_comb begin
        tens  = 4'd0;
        units = 4'd0;
        if (bin >= 5'd30) begin
            tens  = 4'd3;
            units = 4'(bin - 5'd30);
        end else if (bin >= 5'd20) begin
            tens  = 4'd2;
            units = 4'(bin - 5'd20);
        end else if (bin >= 5'd10) begin
            tens  = 4'd1;
            units = 4'(bin - 5'd10);
        end else begin
            tens  = 4'd0;
            units = 4'(bin);
        end
    end

endmodule

// File: rtl/counter_0_31_auto_sel.sv
// Tick counter 0..CNT_MAX with lap counting and automatic frequency-select rotation.
// Drives sel back to the tick mux and BCD digits to the display stage.
module counter_0_31_auto_sel
    import counter_0_31_auto_sel_pkg::*;
#(
    parameter int unsigned CNT_MAX       = DEF_CNT_MAX,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned LAPS_PER_FREQ = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             auto_en,
    input  logic             tick,
    output logic [1:0]       sel,
    output logic [CNT_W-1:0] count,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_units,
    output logic             wrap,
    output logic             freq_chg
);

    localparam logic [CNT_W-1:0] CntMax  = CNT_MAX[CNT_W-1:0];
    localparam logic [LAP_W-1:0] LapLast = LAP_W'(LAPS_PER_FREQ - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [LAP_W-1:0] lap_q, lap_d;
    sel_state_e       state_q, state_d;
    logic             wrap_q, wrap_d;
    logic             freq_chg_q, freq_chg_d;
    logic [4:0]       bcd_in;

    always_comb begin
        count_d    = count_q;
        lap_d      = lap_q;
        state_d    = state_q;
        wrap_d     = 1'b0;
        freq_chg_d = 1'b0;
        if (en && tick) begin
            if (count_q == CntMax) begin
                count_d = '0;
                wrap_d  = 1'b1;
                // With auto_en low the lap count is frozen, not cleared, so progress resumes later.
                if (auto_en) begin
                    if (lap_q == LapLast) begin
                        lap_d      = '0;
                        state_d    = sel_next(state_q);
                        freq_chg_d = 1'b1;
                    end else begin
                        lap_d = lap_q + 1'b1;
                    end
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            lap_q      <= '0;
            state_q    <= StSel05;
            wrap_q     <= 1'b0;
            freq_chg_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            lap_q      <= lap_d;
            state_q    <= state_d;
            wrap_q     <= wrap_d;
            freq_chg_q <= freq_chg_d;
        end
    end

    assign bcd_in = 5'(count_q);

    bin2bcd_5b u_bin2bcd (
        .bin   (bcd_in),
        .tens  (bcd_tens),
        .units (bcd_units)
    );

    assign count    = count_q;
    assign sel      = state_q;
    assign wrap     = wrap_q;
    assign freq_chg = freq_chg_q;

endmodule

// File: tb/tb_counter_0_31_auto_sel.sv
// Directed bench: dut_a uses LAPS_PER_FREQ=1, dut_b uses LAPS_PER_FREQ=2; both share stimulus.
module tb_counter_0_31_auto_sel;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic auto_en = 1'b1;
    logic tick = 1'b0;

    logic [1:0] a_sel, b_sel;
    logic [4:0] a_count, b_count;
    logic [3:0] a_tens, a_units, b_tens, b_units;
    logic       a_wrap, a_fchg, b_wrap, b_fchg;

    int n_checks = 0;
    int n_bad = 0;
    int a_wraps = 0;
    int a_fchgs = 0;
    logic [1:0] a_sel_log[$];

    always #5 clk = ~clk;

    counter_0_31_auto_sel #(.CNT_MAX(31), .CNT_W(5), .LAPS_PER_FREQ(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .auto_en   (auto_en),
        .tick      (tick),
        .sel       (a_sel),
        .count     (a_count),
        .bcd_tens  (a_tens),
        .bcd_units (a_units),
        .wrap      (a_wrap),
        .freq_chg  (a_fchg)
    );

    counter_0_31_auto_sel #(.CNT_MAX(31), .CNT_W(5), .LAPS_PER_FREQ(2)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .auto_en   (auto_en),
        .tick      (tick),
        .sel       (b_sel),
        .count     (b_count),
        .bcd_tens  (b_tens),
        .bcd_units (b_units),
        .wrap      (b_wrap),
        .freq_chg  (b_fchg)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Holds tick high for n cycles; samples on the falling edge after each rising edge.
    task automatic run_ticks(input int n, input bit chk_bcd);
        tick = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (a_wrap) a_wraps++;
            if (a_fchg) begin
                a_fchgs++;
                a_sel_log.push_back(a_sel);
            end
            if (chk_bcd) begin
                check_eq("run_count", int'(a_count), i + 1);
                check_eq("run_tens", int'(a_tens), (i + 1) / 10);
                check_eq("run_units", int'(a_units), (i + 1) % 10);
            end
        end
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        a_wraps = 0;
        a_fchgs = 0;
        a_sel_log.delete();
    endtask

    initial begin
        do_reset();
        check_eq("rst_count", int'(a_count), 0);
        check_eq("rst_sel", int'(a_sel), 0);
        check_eq("rst_wrap", int'(a_wrap), 0);
        check_eq("rst_fchg", int'(a_fchg), 0);
        check_eq("rst_tens", int'(a_tens), 0);
        check_eq("rst_units", int'(a_units), 0);

        // 31 ticks: walk every BCD value up to 31
        run_ticks(31, 1'b1);
        check_eq("t31_count", int'(a_count), 31);
        check_eq("t31_tens", int'(a_tens), 3);
        check_eq("t31_units", int'(a_units), 1);
        check_eq("t31_sel", int'(a_sel), 0);
        check_eq("t31_no_wrap", a_wraps, 0);

        // 32nd tick: wrap and select change, single-cycle pulses
        run_ticks(1, 1'b0);
        check_eq("t32_count", int'(a_count), 0);
        check_eq("t32_wrap", int'(a_wrap), 1);
        check_eq("t32_fchg", int'(a_fchg), 1);
        check_eq("t32_sel", int'(a_sel), 1);
        @(negedge clk);
        check_eq("t33_wrap_low", int'(a_wrap), 0);
        check_eq("t33_fchg_low", int'(a_fchg), 0);
        check_eq("t33_sel_hold", int'(a_sel), 1);

        // 128 ticks from reset: full select rotation
        do_reset();
        run_ticks(128, 1'b0);
        check_eq("r128_wraps", a_wraps, 4);
        check_eq("r128_fchgs", a_fchgs, 4);
        check_eq("r128_sel", int'(a_sel), 0);
        check_eq("r128_log_len", a_sel_log.size(), 4);
        if (a_sel_log.size() == 4) begin
            check_eq("r128_sel0", int'(a_sel_log[0]), 1);
            check_eq("r128_sel1", int'(a_sel_log[1]), 2);
            check_eq("r128_sel2", int'(a_sel_log[2]), 3);
            check_eq("r128_sel3", int'(a_sel_log[3]), 0);
        end

        // en=0 ignores ticks
        run_ticks(5, 1'b0);
        check_eq("en_pre_count", int'(a_count), 5);
        en = 1'b0;
        run_ticks(10, 1'b0);
        check_eq("en0_count", int'(a_count), 5);
        check_eq("en0_sel", int'(b_sel), 2);
        en = 1'b1;
        run_ticks(1, 1'b0);
        check_eq("en1_count", int'(a_count), 6);

        // auto_en=0 across a wrap: sel frozen
        run_ticks(25, 1'b0);
        check_eq("ae_pre_count", int'(a_count), 31);
        auto_en = 1'b0;
        run_ticks(1, 1'b0);
        check_eq("ae0_count", int'(a_count), 0);
        check_eq("ae0_wrap", int'(a_wrap), 1);
        check_eq("ae0_fchg", int'(a_fchg), 0);
        check_eq("ae0_sel", int'(a_sel), 0);
        auto_en = 1'b1;

        // LAPS_PER_FREQ=2 instance
        do_reset();
        run_ticks(32, 1'b0);
        check_eq("b32_sel", int'(b_sel), 0);
        check_eq("b32_wrap", int'(b_wrap), 1);
        check_eq("b32_fchg", int'(b_fchg), 0);
        run_ticks(32, 1'b0);
        check_eq("b64_sel", int'(b_sel), 1);
        check_eq("b64_fchg", int'(b_fchg), 1);
        run_ticks(27, 1'b0);
        check_eq("b27_count", int'(b_count), 27);
        check_eq("b27_tens", int'(b_tens), 2);
        check_eq("b27_units", int'(b_units), 7);

        // Reach count=17, lap=1, sel=2, then reset coincident with a tick
        do_reset();
        run_ticks(177, 1'b0);
        check_eq("brst_pre_sel", int'(b_sel), 2);
        check_eq("brst_pre_count", int'(b_count), 17);
        rst = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick = 1'b0;
        check_eq("brst_count", int'(b_count), 0);
        check_eq("brst_sel", int'(b_sel), 0);
        check_eq("brst_wrap", int'(b_wrap), 0);
        check_eq("brst_fchg", int'(b_fchg), 0);
        // Lap was cleared, so one lap must not advance sel
        run_ticks(32, 1'b0);
        check_eq("brst_lap_sel", int'(b_sel), 0);

        // auto_en off for a lap keeps lap=1; the next enabled lap advances sel
        auto_en = 1'b0;
        run_ticks(32, 1'b0);
        check_eq("bae0_sel", int'(b_sel), 0);
        auto_en = 1'b1;
        run_ticks(32, 1'b0);
        check_eq("bae1_sel", int'(b_sel), 1);
        check_eq("bae1_fchg", int'(b_fchg), 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
